refill_arbiter: RTL
===================

REFILL_ARBITER -- requirements
Module: refill_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15: word-address width of the main-memory port.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter BLOCK_WORDS, default 4: words per cache block; power of two, minimum 2.
REQ-004 Port list, one per line:
  clk  input  1  sole clock; all state changes on posedge.
  rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
  req0, req1  input  1 each  refill request from requester 0 (icache) / requester 1 (dcache).
  addr0, addr1  input  ADDR_W each  miss word address; low log2(BLOCK_WORDS) bits ignored.
  gnt0, gnt1  output  1 each  requester owns the memory port.
  wrData  output  DATA_W  registered refill word.
  wrWord  output  log2(BLOCK_WORDS)  word index of wrData within the block.
  wrEn0, wrEn1  output  1 each  write strobe into cache 0 / 1.
  done0, done1  output  1 each  one-cycle refill-complete pulse.
  memRead  output  1  main-memory read request.
  memAddr  output  ADDR_W  main-memory word address.
  memData  input  DATA_W  main-memory read data.
  dataRdy  input  1  main-memory data-valid handshake.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, READ, RELEASE, DONE.
REQ-006 In IDLE with any req high, the block SHALL select an owner, latch the block base {addrN[ADDR_W-1:log2(BLOCK_WORDS)], zeros}, clear the beat counter, and enter READ on the next edge.
REQ-007 Arbitration SHALL be round-robin: a single requester wins outright; if both req are high, the requester not served last wins; after reset, requester 0 wins ties.
REQ-008 gntN SHALL be high in every READ, RELEASE and DONE cycle of owner N's transfer, and low otherwise; gnt0 and gnt1 SHALL never be high together.
REQ-009 In READ: memRead=1; memAddr = block base + beat. If dataRdy=1, the block SHALL capture memData into wrData, set wrWord=beat, and enter RELEASE.
REQ-010 READ SHALL hold with no timeout while dataRdy=0.
REQ-011 In RELEASE: memRead=0; wrEnN of the owner SHALL be high in the first RELEASE cycle only.
REQ-012 RELEASE SHALL hold until dataRdy=0. Then, if beat = BLOCK_WORDS-1, the block SHALL enter DONE; otherwise it SHALL increment beat and re-enter READ.
REQ-013 In DONE: doneN of the owner SHALL be high for exactly one cycle, the last-served pointer SHALL update to the owner, and the next state SHALL be IDLE.
REQ-014 No grant SHALL issue in the DONE cycle; a new owner is selected only from IDLE, so there is a minimum one-idle-cycle gap between transfers.
REQ-015 Once granted, the transfer SHALL complete all BLOCK_WORDS beats even if the owner drops req; a req toggling mid-transfer SHALL NOT affect the transfer.
REQ-016 Address arithmetic SHALL stay within the block: the beat occupies only the low index bits, with no carry into the tag/index bits.
REQ-017 The beat counter SHALL be log2(BLOCK_WORDS) bits wide and SHALL never wrap during a transfer.
REQ-018 All outputs SHALL be Moore-decoded from state/registers, with no combinational path from req*/addr* to any output; memData is only ever registered.

Reset
REQ-019 While rst=0 at a posedge, the block SHALL enter IDLE and clear beat, wrData, wrWord and the last-served pointer (pointer = 1, so requester 0 wins the first tie).
REQ-020 Resulting output values SHALL be: gnt*, wrEn*, done*, memRead = 0; memAddr = 0.
REQ-021 Reset mid-transfer SHALL abort the transfer with no done pulse; the partially filled block is the requester's responsibility.

Structure
REQ-022 State encoding (refill_state_t) and the default ADDR_W/DATA_W/BLOCK_WORDS values SHALL live in the shared package cache_pkg, reused by the cache controller.
REQ-023 The round-robin pick SHALL be one combinational sub-module, rr_pick2 (inputs req0, req1, last; outputs pick, any), which the block instantiates.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  Single request: req0=1, addr0=0x0123; memory responds after 3 cycles per beat -> memAddr sequence 0x0120..0x0123, four wrEn0 pulses with wrWord 0..3, one done0, gnt1 never high.
  Simultaneous requests after reset: req0=req1=1 -> requester 0 served first, then requester 1 (block 0x0040 for addr1=0x0042), with one IDLE cycle between transfers.
  Fairness: both req held high across three transfers -> grant order 0,1,0.
  Slow handshake: dataRdy held high 5 cycles per beat -> wrEn exactly one cycle per beat, memRead low throughout RELEASE.
  Early drop: req1 dropped after the first beat -> all four beats still delivered, then done1.
  Reset mid-transfer: rst=0 during beat 2 -> next cycle all outputs at reset values, no done pulse; a fresh request then restarts at beat 0.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: refill state encoding and default geometry shared by cache blocks.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, READ, RELEASE, DONE} refill_state_t;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int BLOCK_WORDS_DEF = 4;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; pick=1 selects requester 1.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick,
  output logic any
);
  assign any  = req0 | req1;
  assign pick = req1 & (~req0 | ~last);
endmodule

// File: rtl/refill_arbiter.sv
// refill_arbiter: round-robin owner of the main-memory port, refilling one
// cache block per grant with a four-phase dataRdy handshake per word.
module refill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req0,
  input  logic                           req1,
  input  logic [ADDR_W-1:0]              addr0,
  input  logic [ADDR_W-1:0]              addr1,
  output logic                           gnt0,
  output logic                           gnt1,
  output logic [DATA_W-1:0]              wrData,
  output logic [$clog2(BLOCK_WORDS)-1:0] wrWord,
  output logic                           wrEn0,
  output logic                           wrEn1,
  output logic                           done0,
  output logic                           done1,
  output logic                           memRead,
  output logic [ADDR_W-1:0]              memAddr,
  input  logic [DATA_W-1:0]              memData,
  input  logic                           dataRdy
);
  localparam int LW = $clog2(BLOCK_WORDS);
  localparam int TW = ADDR_W - LW;
  refill_state_t r_state, w_next;
  logic r_owner, r_last, r_wen;
  logic [TW-1:0] r_tag;
  logic [LW-1:0] r_beat, r_wrWord;
  logic [DATA_W-1:0] r_wrData;
  logic w_pick, w_any, w_last_beat, w_busy, w_unused;
  logic [TW-1:0] w_tag;
  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );
  // word-offset bits of the miss address are irrelevant to a block refill
  assign w_unused    = ^{addr0[LW-1:0], addr1[LW-1:0]};
  assign w_tag       = w_pick ? addr1[ADDR_W-1:LW] : addr0[ADDR_W-1:LW];
  assign w_last_beat = r_beat == LW'(BLOCK_WORDS - 1);
  always_comb begin
    w_next = (r_state == IDLE)    ? (w_any ? READ : IDLE) :
             (r_state == READ)    ? (dataRdy ? RELEASE : READ) :
             (r_state == RELEASE) ? (dataRdy ? RELEASE : (w_last_beat ? DONE : READ)) :
                                    IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_wen    <= 1'b0;
      r_tag    <= '0;
      r_beat   <= '0;
      r_wrWord <= '0;
      r_wrData <= '0;
    end else begin
      r_state <= w_next;
      r_wen   <= (r_state == READ) && dataRdy;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_pick;
        r_tag   <= w_tag;
        r_beat  <= '0;
      end
      if (r_state == READ && dataRdy) begin
        r_wrData <= memData;
        r_wrWord <= r_beat;
      end
      if (r_state == RELEASE && !dataRdy && !w_last_beat) r_beat <= r_beat + LW'(1);
      if (r_state == DONE) r_last <= r_owner;
    end
  end
  assign w_busy  = r_state != IDLE;
  assign gnt0    = w_busy & ~r_owner;
  assign gnt1    = w_busy & r_owner;
  assign wrEn0   = r_wen & ~r_owner;
  assign wrEn1   = r_wen & r_owner;
  assign done0   = (r_state == DONE) & ~r_owner;
  assign done1   = (r_state == DONE) & r_owner;
  assign memRead = r_state == READ;
  // beat is concatenated below the tag, so the address never leaves the block
  assign memAddr = memRead ? {r_tag, r_beat} : '0;
  assign wrData  = r_wrData;
  assign wrWord  = r_wrWord;
endmodule
